// File: rtl/ir_rx_pkg.sv
// Shared types and timing windows for the IR frame receiver.
// Window bounds are in duration ticks and are inclusive.
package ir_rx_pkg;

    localparam int DUR_W       = 12;
    localparam int WORD_A_BITS = 35;
    localparam int WORD_B_BITS = 32;

    typedef logic [DUR_W-1:0] dur_t;

    localparam dur_t DUR_MAX        = '1;
    localparam dur_t LEAD_MARK_MIN  = 12'd800;
    localparam dur_t LEAD_MARK_MAX  = 12'd1000;
    localparam dur_t LEAD_SPACE_MIN = 12'd400;
    localparam dur_t LEAD_SPACE_MAX = 12'd500;
    localparam dur_t BIT_MARK_MIN   = 12'd40;
    localparam dur_t BIT_MARK_MAX   = 12'd80;
    localparam dur_t ZERO_SPACE_MIN = 12'd40;
    localparam dur_t ZERO_SPACE_MAX = 12'd80;
    localparam dur_t ONE_SPACE_MIN  = 12'd140;
    localparam dur_t ONE_SPACE_MAX  = 12'd200;
    localparam dur_t CONN_SPACE_MIN = 12'd1800;
    localparam dur_t CONN_SPACE_MAX = 12'd2200;
    localparam dur_t TIMEOUT        = 12'd2500;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_M,
        LEAD_S,
        A_MARK,
        A_SPACE,
        CONN_M,
        CONN_S,
        B_MARK,
        B_SPACE,
        STOP_M
    } rx_state_t;

    function automatic logic in_win(dur_t t, dur_t lo, dur_t hi);
        return (t >= lo) && (t <= hi);
    endfunction

endpackage

// File: rtl/ir_seg_timer.sv
// IR input conditioning: synchronizer, mark normalization, edge detect,
// and a tick-based segment duration counter that restarts on every edge.
module ir_seg_timer
    import ir_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int TICK_US       = 10,
    parameter int IR_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic mark_start,
    output logic mark_end,
    output logic space_end,
    output dur_t seg_ticks
);

    localparam int DIV_RAW = (CLK_FREQ_HZ / 1000) * TICK_US / 1000;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    // The edge cycle itself counts as the first elapsed clock of a segment.
    localparam logic [DIV_W-1:0] DIV_START = DIV_W'((DIV > 1) ? 1 : 0);
    localparam dur_t             DUR_START = dur_t'((DIV > 1) ? 0 : 1);
    localparam logic             IDLE_LVL  = (IR_ACTIVE_LOW != 0);

    logic [1:0]       sync;
    logic             mark;
    logic             mark_q;
    logic             seg_edge;
    logic             tick;
    logic [DIV_W-1:0] div_cnt;

    assign mark       = sync[1] ^ IDLE_LVL;
    assign mark_start = mark & ~mark_q;
    assign mark_end   = ~mark & mark_q;
    assign space_end  = mark_start;
    assign seg_edge   = mark ^ mark_q;
    assign tick       = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= {2{IDLE_LVL}};
            mark_q <= 1'b0;
        end else begin
            sync   <= {sync[0], ir_in};
            mark_q <= mark;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            seg_ticks <= '0;
        end else if (seg_edge) begin
            div_cnt   <= DIV_START;
            seg_ticks <= DUR_START;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick && (seg_ticks != DUR_MAX))
                seg_ticks <= seg_ticks + 1'b1;
        end
    end

endmodule

// File: rtl/ir_frame_receiver.sv
// IR air-conditioner frame decoder: leader, 35-bit word A, connector,
// 32-bit word B, stop mark. Latches good frames, flags bad ones.
module ir_frame_receiver
    import ir_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int TICK_US       = 10,
    parameter int IR_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ir_in,
    output logic [WORD_A_BITS-1:0] data35_out,
    output logic [WORD_B_BITS-1:0] data32_out,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic                   busy,
    output logic                   led_out
);

    logic mark_start;
    logic mark_end;
    logic space_end;
    dur_t seg_ticks;

    rx_state_t              st;
    logic [5:0]             bit_cnt;
    logic [WORD_A_BITS-1:0] sh_a;
    logic [WORD_B_BITS-1:0] sh_b;

    logic lead_m_ok;
    logic lead_s_ok;
    logic mark_ok;
    logic zero_ok;
    logic one_ok;
    logic conn_ok;
    logic bad;
    logic timeout;

    ir_seg_timer #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .TICK_US      (TICK_US),
        .IR_ACTIVE_LOW(IR_ACTIVE_LOW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .ir_in     (ir_in),
        .mark_start(mark_start),
        .mark_end  (mark_end),
        .space_end (space_end),
        .seg_ticks (seg_ticks)
    );

    assign lead_m_ok = in_win(seg_ticks, LEAD_MARK_MIN, LEAD_MARK_MAX);
    assign lead_s_ok = in_win(seg_ticks, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
    assign mark_ok   = in_win(seg_ticks, BIT_MARK_MIN, BIT_MARK_MAX);
    assign zero_ok   = in_win(seg_ticks, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
    assign one_ok    = in_win(seg_ticks, ONE_SPACE_MIN, ONE_SPACE_MAX);
    assign conn_ok   = in_win(seg_ticks, CONN_SPACE_MIN, CONN_SPACE_MAX);
    assign timeout   = (st != IDLE) && (seg_ticks == TIMEOUT);
    assign busy      = (st != IDLE);

    // A segment is judged only on the edge that ends it.
    always_comb begin
        bad = 1'b0;
        unique case (st)
            LEAD_M:  bad = mark_end && !lead_m_ok;
            LEAD_S:  bad = space_end && !lead_s_ok;
            A_MARK,
            CONN_M,
            B_MARK,
            STOP_M:  bad = mark_end && !mark_ok;
            A_SPACE,
            B_SPACE: bad = space_end && !(zero_ok || one_ok);
            CONN_S:  bad = space_end && !conn_ok;
            default: bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            bit_cnt     <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            data35_out  <= '0;
            data32_out  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            led_out     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (bad || timeout) begin
                frame_err <= 1'b1;
                st        <= IDLE;
                bit_cnt   <= '0;
                sh_a      <= '0;
                sh_b      <= '0;
            end else begin
                unique case (st)
                    IDLE:   if (mark_start) st <= LEAD_M;
                    LEAD_M: if (mark_end)   st <= LEAD_S;
                    LEAD_S: if (space_end)  st <= A_MARK;
                    A_MARK: if (mark_end)   st <= A_SPACE;
                    A_SPACE: if (space_end) begin
                        sh_a[bit_cnt] <= one_ok;
                        bit_cnt       <= bit_cnt + 1'b1;
                        if (bit_cnt == 6'(WORD_A_BITS - 1))
                            st <= CONN_M;
                        else
                            st <= A_MARK;
                    end
                    CONN_M: if (mark_end) st <= CONN_S;
                    CONN_S: if (space_end) begin
                        st      <= B_MARK;
                        bit_cnt <= '0;
                    end
                    B_MARK: if (mark_end) st <= B_SPACE;
                    B_SPACE: if (space_end) begin
                        sh_b[bit_cnt[4:0]] <= one_ok;
                        bit_cnt            <= bit_cnt + 1'b1;
                        if (bit_cnt == 6'(WORD_B_BITS - 1))
                            st <= STOP_M;
                        else
                            st <= B_MARK;
                    end
                    STOP_M: if (mark_end) begin
                        data35_out  <= sh_a;
                        data32_out  <= sh_b;
                        frame_valid <= 1'b1;
                        led_out     <= ~led_out;
                        st          <= IDLE;
                        bit_cnt     <= '0;
                        sh_a        <= '0;
                        sh_b        <= '0;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_frame_receiver.sv
// Self-checking bench for ir_frame_receiver: frames are built as lists of
// mark/space durations and judged against the protocol windows.
module tb_ir_frame_receiver;

    localparam int R_LM = 0;
    localparam int R_LS = 1;
    localparam int R_BM = 2;
    localparam int R_BS = 3;
    localparam int R_CS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ir_in = 1'b1;
    logic [34:0] data35_out;
    logic [31:0] data32_out;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;
    logic        led_out;

    // One clock per 10 us tick keeps whole frames short in simulation.
    ir_frame_receiver #(
        .CLK_FREQ_HZ  (100000),
        .TICK_US      (10),
        .IR_ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_in      (ir_in),
        .data35_out (data35_out),
        .data32_out (data32_out),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_valid = 0;
    int   n_err = 0;
    int   valid_cyc = 0;
    int   err_cyc = 0;
    int   busy_cnt = 0;
    int   post_err_busy = 0;
    logic err_d = 1'b0;

    always @(negedge clk) begin
        if (frame_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (err_d && busy) post_err_busy++;
        err_d = frame_err;
        if (busy) busy_cnt++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          seg[$];
    int          role[$];
    int          edge_cyc = 0;
    logic [34:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    logic        exp_led = 1'b0;

    function automatic int rnd(int lo, int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic void add(int r, int t);
        role.push_back(r);
        seg.push_back(t);
    endfunction

    // mode 0 random in-window, 1 nominal, 2 window margins
    function automatic int mark_t(int mode);
        return (mode == 0) ? rnd(40, 80) : (mode == 1) ? 60 : 40;
    endfunction

    function automatic int space_t(int mode, logic b);
        if (b) return (mode == 0) ? rnd(140, 200) : (mode == 1) ? 168 : 200;
        return (mode == 0) ? rnd(40, 80) : (mode == 1) ? 56 : 40;
    endfunction

    function automatic void build(int mode, logic [34:0] a, logic [31:0] b);
        seg.delete();
        role.delete();
        add(R_LM, (mode == 0) ? rnd(800, 1000) : 900);
        add(R_LS, (mode == 0) ? rnd(400, 500) : 450);
        for (int i = 0; i < 35; i++) begin
            add(R_BM, mark_t(mode));
            add(R_BS, space_t(mode, a[i]));
        end
        add(R_BM, mark_t(mode));
        add(R_CS, (mode == 0) ? rnd(1800, 2200) : 2000);
        for (int i = 0; i < 32; i++) begin
            add(R_BM, mark_t(mode));
            add(R_BS, space_t(mode, b[i]));
        end
        add(R_BM, mark_t(mode));
    endfunction

    function automatic int bad_val(int r);
        case (r)
            R_LM:    return 700;
            R_LS:    return 300;
            R_CS:    return 1500;
            default: return 100;
        endcase
    endfunction

    function automatic bit win_ok(int r, int t);
        case (r)
            R_LM:    return t >= 800 && t <= 1000;
            R_LS:    return t >= 400 && t <= 500;
            R_BM:    return t >= 40 && t <= 80;
            R_BS:    return (t >= 40 && t <= 80) || (t >= 140 && t <= 200);
            default: return t >= 1800 && t <= 2200;
        endcase
    endfunction

    task automatic put(input bit mark, input int ticks);
        @(posedge clk);
        #1 ir_in = mark ? 1'b0 : 1'b1;
        edge_cyc = cyc;
        repeat (ticks - 1) @(posedge clk);
    endtask

    task automatic run_frame(input string tag, input int mode,
                             input logic [34:0] a, input logic [31:0] b,
                             input int fidx);
        int last, v0, e0, b0, p0, end_edge;
        bit ok;
        build(mode, a, b);
        if (fidx >= 0) seg[fidx] = bad_val(role[fidx]);
        last = (fidx >= 0) ? fidx : seg.size() - 1;
        ok = 1'b1;
        for (int i = 0; i <= last; i++)
            if (!win_ok(role[i], seg[i])) ok = 1'b0;
        v0 = n_valid;
        e0 = n_err;
        b0 = busy_cnt;
        p0 = post_err_busy;
        for (int i = 0; i <= last; i++) put(i % 2 == 0, seg[i]);
        if (last % 2 == 1) begin
            put(1'b1, 60);
            end_edge = edge_cyc;
            put(1'b0, 200);
        end else begin
            put(1'b0, 200);
            end_edge = edge_cyc;
        end
        if (ok) begin
            exp_a   = a;
            exp_b   = b;
            exp_led = ~exp_led;
        end
        chk({tag, "_valid"}, 64'(n_valid - v0), 64'(ok));
        chk({tag, "_err"}, 64'(n_err - e0), 64'(!ok));
        chk({tag, "_a"}, 64'(data35_out), 64'(exp_a));
        chk({tag, "_b"}, 64'(data32_out), 64'(exp_b));
        chk({tag, "_led"}, 64'(led_out), 64'(exp_led));
        chk({tag, "_busy_seen"}, 64'(busy_cnt > b0), 64'(1));
        if (ok) begin
            chk({tag, "_vlat"}, 64'(valid_cyc - end_edge), 64'(3));
        end else begin
            chk({tag, "_elat"}, 64'(err_cyc - end_edge), 64'(3));
            chk({tag, "_busy_drop"}, 64'(post_err_busy - p0), 64'(0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a"}, 64'(data35_out), 64'(0));
        chk({tag, "_b"}, 64'(data32_out), 64'(0));
        chk({tag, "_valid"}, 64'(frame_valid), 64'(0));
        chk({tag, "_err"}, 64'(frame_err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_led"}, 64'(led_out), 64'(0));
    endtask

    initial begin
        int v0, e0, d, fidx;
        logic [34:0] ra;
        logic [31:0] rb;

        repeat (5) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;
        repeat (20) @(posedge clk);

        run_frame("good1", 1, 35'b11111000001111100000111110000011111,
                  32'b11111000001111100000111110000011, -1);

        ra = {$urandom(), $urandom()};
        rb = $urandom();
        run_frame("lead7ms", 1, ra, rb, 0);

        // Word A stalls after its 12th bit mark; the space runs to 30 ms.
        build(1, ra, rb);
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i <= 24; i++) put(i % 2 == 0, seg[i]);
        put(1'b0, 3000);
        d = err_cyc - edge_cyc;
        chk("tmo_err", 64'(n_err - e0), 64'(1));
        chk("tmo_valid", 64'(n_valid - v0), 64'(0));
        chk("tmo_time", 64'(d >= 2501 && d <= 2505), 64'(1));
        chk("tmo_a", 64'(data35_out), 64'(exp_a));

        // Reset lands in a space during word B.
        build(0, {$urandom(), $urandom()}, $urandom());
        for (int i = 0; i <= 84; i++) put(i % 2 == 0, seg[i]);
        put(1'b0, 50);
        v0 = n_valid;
        e0 = n_err;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_all_zero("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) @(posedge clk);
        #1 check_all_zero("rst_after");
        chk("rst_no_valid", 64'(n_valid - v0), 64'(0));
        chk("rst_no_err", 64'(n_err - e0), 64'(0));
        exp_a   = '0;
        exp_b   = '0;
        exp_led = 1'b0;

        run_frame("good2_margin", 2, 35'd0, 32'hFFFFFFFF, -1);
        run_frame("space1ms", 2, {$urandom(), $urandom()}, $urandom(), 9);

        run_frame("rnd_clean", 0, {$urandom(), $urandom()}, $urandom(), -1);
        fidx = rnd(0, 138);
        run_frame("rnd_fault", 0, {$urandom(), $urandom()}, $urandom(), fidx);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
